// File: rtl/cog_ram_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cog_ram_loader_pkg : shared cog constants and loader state encoding        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package cog_ram_loader_pkg;

  localparam int COG_LONGS   = 496;
  localparam int HUB_LONG_AW = 14;
  localparam int IDX_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cog_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cog_ram_loader : copies COUNT longs from hub RAM into cog RAM port B       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cog_ram_loader
  import cog_ram_loader_pkg::*;
#(
  parameter int COUNT = COG_LONGS,
  parameter int HW    = HUB_LONG_AW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic [HW-1:0] ptr,
  output logic          busy,
  output logic          done,
  output logic          hub_req,
  output logic [HW-1:0] hub_adr,
  input  logic          hub_ack,
  input  logic [31:0]   hub_q,
  output logic          ram_ena,
  output logic          ram_w,
  output logic [8:0]    ram_a,
  output logic [31:0]   ram_d
);

  localparam logic [IDX_W-1:0] C_COUNT = IDX_W'(COUNT);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HW-1:0]    adr_q, adr_d;
  logic [8:0]       ram_a_q, ram_a_d;
  logic [31:0]      ram_d_q, ram_d_d;
  logic             hold_q, hold_d;
  logic [IDX_W-1:0] w_idx_inc;

  assign w_idx_inc = idx_q + IDX_W'(1);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      ram_a_q <= '0;
      ram_d_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      ram_a_q <= ram_a_d;
      ram_d_q <= ram_d_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    ram_a_d = ram_a_q;
    ram_d_d = ram_d_q;
    hold_d  = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_REQ: begin
        if (hub_ack && !hold_q) begin
          ram_d_d = hub_q;
          ram_a_d = idx_q[8:0];
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = w_idx_inc;
        adr_d   = adr_q + HW'(1);
        state_d = (w_idx_inc == C_COUNT) ? ST_DONE : ST_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A start anywhere (re)launches the load; aborting out of REQ masks the
    // request for one cycle so the address can change while hub_req is low.
    if (start) begin
      adr_d   = ptr;
      idx_d   = '0;
      state_d = (COUNT == 0) ? ST_DONE : ST_REQ;
      hold_d  = (state_q == ST_REQ);
    end
  end

  assign busy    = (state_q == ST_REQ) || (state_q == ST_WRITE);
  assign done    = (state_q == ST_DONE);
  assign hub_req = (state_q == ST_REQ) && !hold_q;
  assign hub_adr = adr_q;
  assign ram_ena = (state_q == ST_WRITE);
  assign ram_w   = (state_q == ST_WRITE);
  assign ram_a   = ram_a_q;
  assign ram_d   = ram_d_q;

endmodule
`default_nettype wire

// File: tb/tb_cog_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cog_ram_loader : directed self-checking bench for cog_ram_loader         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cog_ram_loader;

  logic clk;
  logic res;

  // u0: COUNT=496
  logic        start0, ack0, busy0, done0, req0, ena0, w0;
  logic [13:0] ptr0, adr0;
  logic [31:0] q0, d0;
  logic [8:0]  a0;
  // u4: COUNT=4
  logic        start4, ack4, busy4, done4, req4, ena4, w4;
  logic [13:0] ptr4, adr4;
  logic [31:0] q4, d4;
  logic [8:0]  a4;
  // uz: COUNT=0
  logic        startz, ackz, busyz, donez, reqz, enaz, wz;
  logic [13:0] ptrz, adrz;
  logic [31:0] qz, dz;
  logic [8:0]  az;

  cog_ram_loader #(.COUNT(496), .HW(14)) u0 (
    .clk(clk), .res(res), .start(start0), .ptr(ptr0), .busy(busy0), .done(done0),
    .hub_req(req0), .hub_adr(adr0), .hub_ack(ack0), .hub_q(q0),
    .ram_ena(ena0), .ram_w(w0), .ram_a(a0), .ram_d(d0));

  cog_ram_loader #(.COUNT(4), .HW(14)) u4 (
    .clk(clk), .res(res), .start(start4), .ptr(ptr4), .busy(busy4), .done(done4),
    .hub_req(req4), .hub_adr(adr4), .hub_ack(ack4), .hub_q(q4),
    .ram_ena(ena4), .ram_w(w4), .ram_a(a4), .ram_d(d4));

  cog_ram_loader #(.COUNT(0), .HW(14)) uz (
    .clk(clk), .res(res), .start(startz), .ptr(ptrz), .busy(busyz), .done(donez),
    .hub_req(reqz), .hub_adr(adrz), .hub_ack(ackz), .hub_q(qz),
    .ram_ena(enaz), .ram_w(wz), .ram_a(az), .ram_d(dz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dly;
    logic [31:0] data;
    logic [13:0] adr;
    logic [8:0]  a;
  } vec_t;

  vec_t tv[4];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  int          max_dly = 0;
  int          wait_cnt = 0;
  int          model_idx = 0;
  logic [13:0] model_adr = '0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          first_req = -1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge, score u0 against the address model,
  // then act as u0's hub responder for the next rising edge.
  task automatic step();
    logic sa;
    @(negedge clk);
    cyc++;
    sa = ack0;
    if (mon_en) begin
      if (w0 || sa) begin
        check("u0 write after ack", 64'({sa, w0, a0, d0}),
              64'({1'b1, 1'b1, 9'(model_idx), 18'b0, model_adr}));
        if (w0) begin
          model_idx++;
          model_adr = model_adr + 14'd1;
          wr_cnt++;
        end
      end
      if (req0) check("u0 hub_adr", 64'(adr0), 64'(model_adr));
      if (done0) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (req0 && first_req < 0) first_req = cyc;
      ack0 = 1'b0;
      q0   = 32'hA5A5_A5A5;
      if (req0) begin
        if (wait_cnt == 0) begin
          ack0     = 1'b1;
          q0       = {18'b0, model_adr};
          wait_cnt = int'($urandom_range(max_dly, 0));
        end else begin
          wait_cnt--;
        end
      end
    end
  endtask

  task automatic kick0(input logic [13:0] p);
    start0    = 1'b1;
    ptr0      = p;
    ack0      = 1'b0;
    model_adr = p;
    model_idx = 0;
    wait_cnt  = 0;
    first_req = -1;
    step();
    start0 = 1'b0;
    check("u0 busy after start", 64'(busy0), 64'(1));
  endtask

  initial begin
    tv[0] = '{0, 32'hDEAD_0001, 14'h3FFE, 9'd0};
    tv[1] = '{3, 32'hCAFE_0002, 14'h3FFF, 9'd1};
    tv[2] = '{0, 32'h1234_5678, 14'h0000, 9'd2};
    tv[3] = '{5, 32'h0BAD_F00D, 14'h0001, 9'd3};

    res = 1'b1;
    start0 = 0; ptr0 = '0; ack0 = 0; q0 = '0;
    start4 = 0; ptr4 = '0; ack4 = 0; q4 = '0;
    startz = 0; ptrz = '0; ackz = 0; qz = '0;

    step();
    check("u0 reset outputs", 64'({busy0, done0, req0, adr0, ena0, w0, a0, d0}), 64'(0));
    check("u4 reset outputs", 64'({busy4, done4, req4, adr4, ena4, w4, a4, d4}), 64'(0));
    check("uz reset outputs", 64'({busyz, donez, reqz, adrz, enaz, wz, az, dz}), 64'(0));
    res = 1'b0;
    step();

    // Reset asserted between edges while u0 is requesting.
    start0 = 1'b1; ptr0 = 14'h0055;
    step();
    start0 = 1'b0;
    check("u0 req before reset", 64'({req0, adr0}), 64'({1'b1, 14'h0055}));
    #2 res = 1'b1;
    #1 check("u0 outputs in async reset", 64'({busy0, done0, req0, adr0, ena0, w0, a0, d0}), 64'(0));
    step();
    res = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("u0 idle after reset", 64'({busy0, req0, w0, done0}), 64'(0));
    end

    // u4: address wrap and hand-paced acks from the vector table.
    start4 = 1'b1; ptr4 = 14'h3FFE;
    step();
    start4 = 1'b0;
    check("u4 busy after start", 64'(busy4), 64'(1));
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < tv[i].dly; d++) begin
        check("u4 waiting req", 64'({req4, adr4, w4}), 64'({1'b1, tv[i].adr, 1'b0}));
        step();
      end
      check("u4 req at ack", 64'({req4, adr4}), 64'({1'b1, tv[i].adr}));
      ack4 = 1'b1; q4 = tv[i].data;
      step();
      ack4 = 1'b0; q4 = 32'hFFFF_FFFF;
      check("u4 write", 64'({ena4, w4, a4, d4, req4}), 64'({1'b1, 1'b1, tv[i].a, tv[i].data, 1'b0}));
      step();
    end
    check("u4 done pulse", 64'({done4, busy4}), 64'({1'b1, 1'b0}));
    step();
    check("u4 back to idle", 64'({done4, busy4, req4}), 64'(0));
    ack4 = 1'b1; q4 = 32'h1111_2222;
    step();
    ack4 = 1'b0;
    check("u4 ack in idle ignored", 64'({busy4, w4, req4, done4}), 64'(0));
    step();
    check("u4 still idle", 64'({busy4, w4, req4, done4, d4}), 64'({4'b0, 32'h0BAD_F00D}));

    // uz: zero-length load, done in the cycle right after the start cycle.
    startz = 1'b1; ptrz = 14'h0123;
    step();
    startz = 1'b0;
    check("uz done after start", 64'({donez, busyz, reqz, wz}), 64'({1'b1, 3'b0}));
    for (int i = 0; i < 4; i++) begin
      step();
      check("uz quiet", 64'({donez, busyz, reqz, wz}), 64'(0));
    end

    // u0: full load with zero-wait acks.
    mon_en = 1'b1; max_dly = 0; wr_cnt = 0; done_cnt = 0;
    kick0(14'h0100);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    check("u0 full load done count", 64'(done_cnt), 64'(1));
    check("u0 full load writes", 64'(wr_cnt), 64'(496));
    check("u0 cycles first REQ..done inclusive", 64'(done_cyc - first_req + 1), 64'(993));
    step();
    check("u0 idle after load", 64'({busy0, done0, req0}), 64'(0));

    // u0: random ack delays, restart from 0x80 after three writes at 0x10.
    max_dly = 20; wr_cnt = 0; done_cnt = 0;
    kick0(14'h0010);
    for (int i = 0; i < 2000 && wr_cnt < 3; i++) step();
    check("u0 three writes before restart", 64'(wr_cnt), 64'(3));
    step();
    check("u0 requesting before restart", 64'(req0), 64'(1));
    kick0(14'h0080);
    check("u0 req drops on abort", 64'(req0), 64'(0));
    for (int i = 0; i < 20000 && done_cnt == 0; i++) step();
    check("u0 restart done count", 64'(done_cnt), 64'(1));
    check("u0 restart total writes", 64'(wr_cnt), 64'(3 + 496));
    for (int i = 0; i < 5; i++) step();
    check("u0 single done pulse", 64'(done_cnt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
